ef_i2c_apb_seq: RTL and testbench

Autonomous APB master sequencer that sits directly upstream of the I2C APB wrapper. It executes a small instruction program (typically a sensor bring-up script) from an external synchronous ROM/RAM and turns each instruction into APB transfers into the I2C block: register writes, reads, status polls and delays. Software, or a boot FSM, only pulses `start` and watches `done`/`err`. The CPU no longer has to babysit I2C initialisation.

---
 rtl/ef_i2c_apb_seq_pkg.sv | 41 ++++
 rtl/ef_i2c_apb_seq_apb_master_if.sv | 75 +++++++
 rtl/ef_i2c_apb_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_ef_i2c_apb_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_i2c_apb_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ef_i2c_apb_seq_pkg                                                 |
// | Opcodes, error codes, FSM encoding and instruction layout.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ef_i2c_apb_seq_pkg;

  localparam logic [3:0] OP_END  = 4'd0;
  localparam logic [3:0] OP_WR   = 4'd1;
  localparam logic [3:0] OP_RD   = 4'd2;
  localparam logic [3:0] OP_POLL = 4'd3;
  localparam logic [3:0] OP_WAIT = 4'd4;

  localparam logic [1:0] ERR_APB_TMO  = 2'd0;
  localparam logic [1:0] ERR_POLL_TMO = 2'd1;
  localparam logic [1:0] ERR_ILL_OP   = 2'd2;
  localparam logic [1:0] ERR_PC_OVF   = 2'd3;

  localparam int INSTR_W = 52;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_SETUP  = 3'd3,
    ST_ACCESS = 3'd4,
    ST_DELAY  = 3'd5,
    ST_ERROR  = 3'd6
  } seq_state_t;

  // Field order fixes bit positions: op[51:48] addr[47:32] data[31:16] mask[15:0]
  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] mask;
  } instr_t;

endpackage
`default_nettype wire

// File: rtl/ef_i2c_apb_seq_apb_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ef_apb_master_if                                                   |
// | APB SETUP/ACCESS handshake with ACCESS-phase timeout.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ef_apb_master_if #(
  parameter int APB_TIMEOUT = 255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        i_req,
  input  logic        i_req_write,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_ack,
  output logic        o_tmo,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_paddr,
  output logic [31:0] o_pwdata,
  input  logic        i_pready
);

  localparam int            c_tw       = $clog2(APB_TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(APB_TIMEOUT - 1);

  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [15:0]     r_addr;
  logic [15:0]     r_wdata;
  logic [c_tw-1:0] r_tmo_cnt;
  logic            w_access;

  assign w_access = r_psel & r_penable;
  assign o_ack    = w_access & i_pready;
  assign o_tmo    = w_access & ~i_pready & (r_tmo_cnt == c_tmo_last);

  // A new request is accepted when idle or back-to-back on the completing ACCESS
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tmo_cnt <= '0;
    end else if (i_req && (!r_psel || o_ack)) begin
      r_psel    <= 1'b1;
      r_penable <= 1'b0;
      r_pwrite  <= i_req_write;
      r_addr    <= i_req_addr;
      r_wdata   <= i_req_wdata;
      r_tmo_cnt <= '0;
    end else if (o_ack || o_tmo) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else if (r_psel && !r_penable) begin
      r_penable <= 1'b1;
      r_tmo_cnt <= '0;
    end else if (w_access) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_pwrite;
  assign o_paddr   = {16'h0000, r_addr};
  assign o_pwdata  = {16'h0000, r_wdata};

endmodule
`default_nettype wire

// File: rtl/ef_i2c_apb_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ef_i2c_apb_seq                                                     |
// | Program-driven APB master that scripts the I2C wrapper registers.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ef_i2c_apb_seq
  import ef_i2c_apb_seq_pkg::*;
#(
  parameter int PROG_AW     = 6,
  parameter int APB_TIMEOUT = 255,
  parameter int POLL_LIMIT  = 1024
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               start,
  input  logic               abort,
  output logic [PROG_AW-1:0] prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PADDR,
  output logic [31:0]        PWDATA,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [15:0]        rd_data
);

  localparam int             c_pcw       = $clog2(POLL_LIMIT + 1);
  localparam logic [c_pcw-1:0] c_poll_last = c_pcw'(POLL_LIMIT - 1);

  seq_state_t          r_state;
  logic [PROG_AW-1:0]  r_pc;
  instr_t              r_ins;
  logic [15:0]         r_dly;
  logic [c_pcw-1:0]    r_poll_cnt;
  logic                r_abort_pend;
  logic [1:0]          r_pend_code;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic [15:0]         r_rd_data;

  instr_t              w_ins;
  instr_t              w_req_ins;
  logic                w_ack;
  logic                w_tmo;
  logic                w_req;
  logic                w_abort;
  logic                w_match;
  logic                w_poll_last;
  logic                w_poll_retry;
  logic                w_pc_last;
  logic                w_unused_prdata;

  assign w_ins           = instr_t'(prog_data);
  assign w_abort         = abort | r_abort_pend;
  assign w_match         = ((PRDATA[15:0] ^ r_ins.data) & r_ins.mask) == 16'h0000;
  assign w_poll_last     = (r_poll_cnt == c_poll_last);
  assign w_pc_last       = &r_pc;
  assign w_unused_prdata = ^PRDATA[31:16];

  // Must mirror the ACCESS branch below that returns to SETUP for another poll read
  assign w_poll_retry = (r_state == ST_ACCESS) && w_ack && (r_ins.op == OP_POLL) &&
                        !w_match && !w_poll_last && !w_abort;
  assign w_req = ((r_state == ST_DECODE) && !abort &&
                  ((w_ins.op == OP_WR) || (w_ins.op == OP_RD) || (w_ins.op == OP_POLL))) ||
                 w_poll_retry;
  assign w_req_ins = (r_state == ST_DECODE) ? w_ins : r_ins;

  ef_apb_master_if #(
    .APB_TIMEOUT (APB_TIMEOUT)
  ) u_apb (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .i_req       (w_req),
    .i_req_write (w_req_ins.op == OP_WR),
    .i_req_addr  (w_req_ins.addr),
    .i_req_wdata (w_req_ins.data),
    .o_ack       (w_ack),
    .o_tmo       (w_tmo),
    .o_psel      (PSEL),
    .o_penable   (PENABLE),
    .o_pwrite    (PWRITE),
    .o_paddr     (PADDR),
    .o_pwdata    (PWDATA),
    .i_pready    (PREADY)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_ins        <= '0;
      r_dly        <= '0;
      r_poll_cnt   <= '0;
      r_abort_pend <= 1'b0;
      r_pend_code  <= ERR_APB_TMO;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_APB_TMO;
      r_rd_data    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_abort_pend <= 1'b0;
          if (start && !abort) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ins      <= w_ins;
            r_poll_cnt <= '0;
            case (w_ins.op)
              OP_END: begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
              OP_WR, OP_RD, OP_POLL: r_state <= ST_SETUP;
              OP_WAIT: begin
                if (w_ins.data != 16'h0000) begin
                  r_dly   <= w_ins.data;
                  r_state <= ST_DELAY;
                end else if (w_pc_last) begin
                  r_pend_code <= ERR_PC_OVF;
                  r_state     <= ST_ERROR;
                end else begin
                  r_pc    <= r_pc + 1'b1;
                  r_state <= ST_FETCH;
                end
              end
              default: begin
                r_pend_code <= ERR_ILL_OP;
                r_state     <= ST_ERROR;
              end
            endcase
          end
        end
        ST_SETUP: begin
          if (abort) r_abort_pend <= 1'b1;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (abort) r_abort_pend <= 1'b1;
          if (w_tmo) begin
            if (w_abort) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_pend_code <= ERR_APB_TMO;
              r_state     <= ST_ERROR;
            end
          end else if (w_ack) begin
            if (r_ins.op != OP_WR) r_rd_data <= PRDATA[15:0];
            if (w_abort) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if ((r_ins.op == OP_POLL) && !w_match) begin
              if (w_poll_last) begin
                r_pend_code <= ERR_POLL_TMO;
                r_state     <= ST_ERROR;
              end else begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
                r_state    <= ST_SETUP;
              end
            end else if (w_pc_last) begin
              r_pend_code <= ERR_PC_OVF;
              r_state     <= ST_ERROR;
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DELAY: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_dly != 16'd1) begin
            r_dly <= r_dly - 16'd1;
          end else if (w_pc_last) begin
            r_pend_code <= ERR_PC_OVF;
            r_state     <= ST_ERROR;
          end else begin
            r_pc    <= r_pc + 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_ERROR: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!abort) begin
            r_err      <= 1'b1;
            r_err_code <= r_pend_code;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign prog_addr = r_pc;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ef_i2c_apb_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ef_i2c_apb_seq                                                  |
// | Scoreboard bench: program ROM, I2C-register APB slave, monitor.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ef_i2c_apb_seq;

  localparam int AW   = 6;
  localparam int TMO  = 20;
  localparam int PLIM = 4;
  localparam int K_APB  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] prog_addr;
  logic [51:0]   prog_data;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PADDR, PWDATA, PRDATA;
  logic          PREADY;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [15:0]   rd_data;

  ef_i2c_apb_seq #(.PROG_AW(AW), .APB_TIMEOUT(TMO), .POLL_LIMIT(PLIM)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .abort(abort),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .rd_data(rd_data)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          kind;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          acc;
    logic [1:0]  code;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          pen_cycles = 0;
  int          done_cycles = 0;
  logic [51:0] prog [64];
  logic [15:0] regs [32];
  logic [15:0] poll_vals[$];
  bit          never_ready = 1'b0;
  bit          poll_mode = 1'b0;

  always @(posedge PCLK) prog_data <= prog[prog_addr];

  function automatic logic [51:0] ins(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] d, input logic [15:0] m);
    return {op, a, d, m};
  endfunction

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic push_apb(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input int acc);
    exp_t e;
    e.kind = K_APB; e.wr = wr; e.addr = a; e.data = d; e.acc = acc; e.code = 2'd0;
    expq.push_back(e);
  endtask

  task automatic push_ev(input int kind, input logic [1:0] code);
    exp_t e;
    e.kind = kind; e.wr = 1'b0; e.addr = 16'h0; e.data = 16'h0; e.acc = 0; e.code = code;
    expq.push_back(e);
  endtask

  task automatic pop_exp(input int kind, output exp_t e, output bit got);
    got = 1'b0;
    e.kind = -1; e.wr = 1'b0; e.addr = 16'h0; e.data = 16'h0; e.acc = 0; e.code = 2'd0;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = expq.pop_front();
      check("event_kind", e.kind == kind, kind, e.kind);
      got = (e.kind == kind);
    end
  endtask

  // Slave: I2C wrapper registers at 0xFF00-0xFF1F take one wait state
  initial begin
    int wcnt;
    int waits;
    wcnt = 0;
    PREADY = 1'b0;
    PRDATA = 32'h0;
    forever begin
      @(posedge PCLK);
      #1;
      waits = (PADDR[15:5] == 11'h7F8) ? 1 : 0;
      if (PSEL && !PENABLE) begin
        wcnt = 0;
        PREADY = 1'b0;
      end else if (PSEL && PENABLE) begin
        PREADY = !never_ready && (wcnt >= waits);
        wcnt++;
        if (PREADY) begin
          if (PWRITE) begin
            if (PADDR[15:5] == 11'h7F8) regs[PADDR[4:0]] = PWDATA[15:0];
          end else if (poll_mode) begin
            PRDATA = (poll_vals.size() > 0) ? {16'hA5A5, poll_vals.pop_front()} : 32'hA5A50000;
          end else begin
            PRDATA = {16'hA5A5, regs[PADDR[4:0]]};
          end
        end
      end else begin
        PREADY = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    int   acc_cnt;
    logic prev_err;
    logic prev_done;
    exp_t e;
    bit   got;
    acc_cnt = 0; prev_err = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn || !PSEL) acc_cnt = 0;
      if (PRESETn) begin
        if (PSEL && PENABLE) begin
          acc_cnt++;
          pen_cycles++;
        end
        if (PSEL && PENABLE && PREADY) begin
          pop_exp(K_APB, e, got);
          if (got) begin
            check("apb_dir_addr", {PWRITE, PADDR} == {e.wr, 16'h0000, e.addr},
                  {PWRITE, PADDR}, {e.wr, 16'h0000, e.addr});
            if (e.wr) check("apb_wdata", PWDATA == {16'h0000, e.data}, PWDATA, e.data);
            check("apb_access_len", acc_cnt == e.acc, acc_cnt, e.acc);
          end
          acc_cnt = 0;
        end
        if (done) done_cycles++;
        if (done && !prev_done) begin
          pop_exp(K_DONE, e, got);
          check("done_busy_low", !busy, busy, 0);
        end
        if (err && !prev_err) begin
          pop_exp(K_ERR, e, got);
          if (got) check("err_code", err_code == e.code, err_code, e.code);
        end
      end
      prev_done = done;
      prev_err  = err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 52'h0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge PCLK);
      n++;
    end
    check(name, !busy, busy, 0);
    repeat (2) @(negedge PCLK);
  endtask

  task automatic pulse_start();
    @(negedge PCLK);
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    for (int i = 0; i < 32; i++) regs[i] = 16'h0;
    clear_prog();
    repeat (2) @(negedge PCLK);
    check("rst_apb_ctl", {PSEL, PENABLE, PWRITE} == 3'b000, {PSEL, PENABLE, PWRITE}, 0);
    check("rst_paddr_pwdata", {PADDR, PWDATA} == 64'h0, {PADDR, PWDATA}, 0);
    check("rst_prog_addr", prog_addr == '0, prog_addr, 0);
    check("rst_status", {busy, done, err, err_code} == 5'b0, {busy, done, err, err_code}, 0);
    check("rst_rd_data", rd_data == 16'h0, rd_data, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Bring-up writes plus readback
    prog[0] = ins(4'd1, 16'hFF10, 16'h0001, 16'h0);
    prog[1] = ins(4'd1, 16'hFF00, 16'h01FF, 16'h0);
    prog[2] = ins(4'd2, 16'hFF00, 16'h1234, 16'h0);
    prog[3] = ins(4'd0, 16'h0, 16'h0, 16'h0);
    push_apb(1'b1, 16'hFF10, 16'h0001, 2);
    push_apb(1'b1, 16'hFF00, 16'h01FF, 2);
    push_apb(1'b0, 16'hFF00, 16'h0000, 2);
    push_ev(K_DONE, 2'd0);
    done_cycles = 0;
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge PCLK);
      start = 1'b0;
      lat++;
    end while (!PSEL && lat < 10);
    check("psel_latency", lat == 3, lat, 3);
    check("busy_during_run", busy, busy, 1);
    wait_idle("prog1_finish", 100);
    check("gclk_readback", regs[16] == 16'h0001, regs[16], 1);
    check("rd_data_ff00", rd_data == 16'h01FF, rd_data, 16'h01FF);
    check("done_width", done_cycles == 1, done_cycles, 1);

    // POLL: three mismatches under mask then a match
    poll_mode = 1'b1;
    poll_vals = '{16'h0002, 16'h0000, 16'hFFFE, 16'h0003};
    clear_prog();
    prog[0] = ins(4'd3, 16'hFF04, 16'h0001, 16'h0001);
    for (int i = 0; i < 4; i++) push_apb(1'b0, 16'hFF04, 16'h0, 2);
    push_ev(K_DONE, 2'd0);
    done_cycles = 0;
    pulse_start();
    wait_idle("poll_finish", 100);
    check("poll_rd_data", rd_data == 16'h0003, rd_data, 16'h0003);
    check("poll_vals_used", poll_vals.size() == 0, poll_vals.size(), 0);
    check("poll_done_width", done_cycles == 1, done_cycles, 1);

    // POLL limit reached
    poll_vals = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < PLIM; i++) push_apb(1'b0, 16'hFF04, 16'h0, 2);
    push_ev(K_ERR, 2'd1);
    done_cycles = 0;
    pulse_start();
    wait_idle("poll_lim_finish", 100);
    check("poll_lim_err", {err, err_code} == 3'b101, {err, err_code}, 3'b101);
    check("poll_lim_no_done", done_cycles == 0, done_cycles, 0);
    check("poll_lim_reads", poll_vals.size() == 1, poll_vals.size(), 1);
    poll_mode = 1'b0;

    // APB timeout
    never_ready = 1'b1;
    prog[0] = ins(4'd2, 16'h0100, 16'h0, 16'h0);
    push_ev(K_ERR, 2'd0);
    pen_cycles = 0;
    pulse_start();
    wait_idle("tmo_finish", 200);
    check("tmo_access_cycles", pen_cycles == TMO, pen_cycles, TMO);
    check("tmo_psel_dropped", {PSEL, PENABLE} == 2'b00, {PSEL, PENABLE}, 0);
    check("tmo_err", {err, err_code} == 3'b100, {err, err_code}, 3'b100);
    never_ready = 1'b0;

    // Illegal opcode
    prog[0] = ins(4'd7, 16'h0, 16'h0, 16'h0);
    push_ev(K_ERR, 2'd2);
    pulse_start();
    wait_idle("illegal_finish", 50);

    // 64 instructions without END
    for (int i = 0; i < 64; i++) prog[i] = ins(4'd4, 16'h0, 16'h0, 16'h0);
    push_ev(K_ERR, 2'd3);
    pulse_start();
    wait_idle("pc_ovf_finish", 400);
    check("pc_ovf_prog_addr", prog_addr == 6'd63, prog_addr, 63);

    // Abort during WAIT 100
    clear_prog();
    prog[0] = ins(4'd4, 16'h0, 16'd100, 16'h0);
    done_cycles = 0;
    pulse_start();
    repeat (10) @(negedge PCLK);
    check("wait_still_busy", busy, busy, 1);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    check("abort_idle", {busy, err, done} == 3'b000, {busy, err, done}, 0);
    repeat (2) @(negedge PCLK);
    check("abort_no_done", done_cycles == 0, done_cycles, 0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    abort = 1'b0;
    @(negedge PCLK);
    check("start_abort_idle", busy == 1'b0, busy, 0);

    // Async reset during ACCESS
    never_ready = 1'b1;
    prog[0] = ins(4'd1, 16'hFF00, 16'h0005, 16'h0);
    pulse_start();
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check("reach_access", PENABLE, PENABLE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_access",
          {PSEL, PENABLE, PWRITE, PADDR, PWDATA, prog_addr, busy, done, err, err_code, rd_data} == '0,
          {PSEL, PENABLE, PWRITE, busy, done, err}, 0);
    @(negedge PCLK);
    never_ready = 1'b0;
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    check("scoreboard_empty", expq.size() == 0, expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
